// File: rtl/sync_edge_filter.sv
// Debounces a synchronized level and emits qualified rise/fall pulses plus a rising-edge count.
// Optional build macro EDGE_CNT_SAT_EN: edge_count saturates at all-ones instead of wrapping.
module sync_edge_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter bit          RST_LEVEL     = 1'b0
) (
    input  logic             dst_clk,
    input  logic             rst,
    input  logic             sync_in,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count
);

    // Guarded so an illegal STABLE_CYCLES reaches the $error below instead of a zero-width vector.
    localparam int unsigned STAB_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 65535)) begin : g_bad_stable_cycles
        $error("sync_edge_filter: STABLE_CYCLES must be in 2..65535");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sync_edge_filter: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam state_t RST_STATE = (RST_LEVEL != 1'b0) ? STABLE_HI : STABLE_LO;

    state_t            r_state;
    logic [STAB_W-1:0] r_stab_cnt;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;
    logic [CNT_W-1:0]  r_edge_cnt;

    state_t            w_state;
    logic [STAB_W-1:0] w_stab_cnt;
    logic              w_level;
    logic              w_rise;
    logic              w_fall;
    logic [CNT_W-1:0]  w_edge_cnt;

    always_ff @(posedge dst_clk or posedge rst) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_stab_cnt <= '0;
            r_level    <= RST_LEVEL;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_stab_cnt <= w_stab_cnt;
            r_level    <= w_level;
            r_rise     <= w_rise;
            r_fall     <= w_fall;
            r_edge_cnt <= w_edge_cnt;
        end
    end

    // Stability FSM: a new level must be seen STABLE_CYCLES samples in a row to be accepted.
    always_comb begin
        w_state    = r_state;
        w_stab_cnt = r_stab_cnt;
        w_level    = r_level;
        w_rise     = 1'b0;
        w_fall     = 1'b0;
        unique case (r_state)
            STABLE_LO: begin
                if (sync_in) begin
                    w_state    = CHK_HI;
                    w_stab_cnt = STAB_W'(1);
                end
            end
            CHK_HI: begin
                if (!sync_in) begin
                    w_state    = STABLE_LO;
                    w_stab_cnt = '0;
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_state    = STABLE_HI;
                    w_stab_cnt = '0;
                    w_level    = 1'b1;
                    w_rise     = 1'b1;
                end else begin
                    w_stab_cnt = r_stab_cnt + STAB_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_in) begin
                    w_state    = CHK_LO;
                    w_stab_cnt = STAB_W'(1);
                end
            end
            CHK_LO: begin
                if (sync_in) begin
                    w_state    = STABLE_HI;
                    w_stab_cnt = '0;
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_state    = STABLE_LO;
                    w_stab_cnt = '0;
                    w_level    = 1'b0;
                    w_fall     = 1'b1;
                end else begin
                    w_stab_cnt = r_stab_cnt + STAB_W'(1);
                end
            end
            default: begin
                w_state    = RST_STATE;
                w_stab_cnt = '0;
            end
        endcase
    end

    // Clear wins over a same-edge rise, so that rise is not counted.
    always_comb begin
        w_edge_cnt = r_edge_cnt;
        if (cnt_clr) begin
            w_edge_cnt = '0;
        end else if (w_rise) begin
`ifdef EDGE_CNT_SAT_EN
            if (r_edge_cnt != CNT_MAX) begin
                w_edge_cnt = r_edge_cnt + CNT_W'(1);
            end
`else
            w_edge_cnt = r_edge_cnt + CNT_W'(1);
`endif
        end
    end

    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign edge_count = r_edge_cnt;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Directed and random checks of sync_edge_filter with STABLE_CYCLES=4, CNT_W=4, RST_LEVEL=0.
module tb_sync_edge_filter;

    localparam int unsigned SC = 4;
    localparam int unsigned CW = 4;

    logic          dst_clk = 1'b0;
    logic          rst     = 1'b0;
    logic          sync_in = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          level_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] edge_count;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic          m_level = 1'b0;
    int            m_run   = 0;
    logic          m_rise  = 1'b0;
    logic          m_fall  = 1'b0;
    logic [CW-1:0] m_cnt   = '0;

    sync_edge_filter #(
        .STABLE_CYCLES(SC),
        .CNT_W        (CW),
        .RST_LEVEL    (1'b0)
    ) dut (
        .dst_clk   (dst_clk),
        .rst       (rst),
        .sync_in   (sync_in),
        .cnt_clr   (cnt_clr),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .edge_count(edge_count)
    );

    always #5 dst_clk = ~dst_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_level = 1'b0;
        m_run   = 0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (sync_in != m_level) begin
                m_run++;
                if (m_run == SC) begin
                    m_level = sync_in;
                    m_run   = 0;
                    if (sync_in) m_rise = 1'b1;
                    else         m_fall = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            if (cnt_clr) begin
                m_cnt = '0;
            end else if (m_rise) begin
`ifdef EDGE_CNT_SAT_EN
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
`else
                m_cnt = m_cnt + CW'(1);
`endif
            end
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge dst_clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        sync_in = 1'b1;
        rst     = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL reset_level: got %b want 0", level_out); end
        n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL reset_rise: got %b want 0", rise_pulse); end
        n_vec++; if (fall_pulse !== 1'b0) begin n_miss++; $display("FAIL reset_fall: got %b want 0", fall_pulse); end
        n_vec++; if (edge_count !== 4'd0) begin n_miss++; $display("FAIL reset_count: got %0d want 0", edge_count); end
        for (int i = 0; i < 3; i++) step();
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL reset_held_level: got %b want 0", level_out); end
        n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL reset_held_rise: got %b want 0", rise_pulse); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL post_reset_wait_level[%0d]: got %b want 0", i, level_out); end
            n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL post_reset_wait_rise[%0d]: got %b want 0", i, rise_pulse); end
        end
        step();
        n_vec++; if (level_out !== 1'b1) begin n_miss++; $display("FAIL post_reset_level: got %b want 1", level_out); end
        n_vec++; if (rise_pulse !== 1'b1) begin n_miss++; $display("FAIL post_reset_rise: got %b want 1", rise_pulse); end
        n_vec++; if (edge_count !== 4'd1) begin n_miss++; $display("FAIL post_reset_count: got %0d want 1", edge_count); end
        step();
        n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL post_reset_rise_width: got %b want 0", rise_pulse); end
        n_vec++; if (level_out !== 1'b1) begin n_miss++; $display("FAIL post_reset_level_hold: got %b want 1", level_out); end
    endtask

    task automatic test_fall();
        sync_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (level_out !== 1'b1) begin n_miss++; $display("FAIL fall_wait_level[%0d]: got %b want 1", i, level_out); end
            n_vec++; if (fall_pulse !== 1'b0) begin n_miss++; $display("FAIL fall_wait_pulse[%0d]: got %b want 0", i, fall_pulse); end
        end
        step();
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL fall_level: got %b want 0", level_out); end
        n_vec++; if (fall_pulse !== 1'b1) begin n_miss++; $display("FAIL fall_pulse: got %b want 1", fall_pulse); end
        n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL fall_no_rise: got %b want 0", rise_pulse); end
        n_vec++; if (edge_count !== 4'd1) begin n_miss++; $display("FAIL fall_count: got %0d want 1", edge_count); end
        step();
        n_vec++; if (fall_pulse !== 1'b0) begin n_miss++; $display("FAIL fall_pulse_width: got %b want 0", fall_pulse); end
    endtask

    task automatic test_glitch();
        sync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL glitch_level[%0d]: got %b want 0", i, level_out); end
            n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL glitch_rise[%0d]: got %b want 0", i, rise_pulse); end
        end
        sync_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL glitch_after_level[%0d]: got %b want 0", i, level_out); end
            n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL glitch_after_rise[%0d]: got %b want 0", i, rise_pulse); end
        end
        n_vec++; if (edge_count !== 4'd1) begin n_miss++; $display("FAIL glitch_count: got %0d want 1", edge_count); end
        sync_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL qualify_3rd_level: got %b want 0", level_out); end
        step();
        n_vec++; if (level_out !== 1'b1) begin n_miss++; $display("FAIL qualify_4th_level: got %b want 1", level_out); end
        n_vec++; if (rise_pulse !== 1'b1) begin n_miss++; $display("FAIL qualify_4th_rise: got %b want 1", rise_pulse); end
        n_vec++; if (edge_count !== 4'd2) begin n_miss++; $display("FAIL qualify_count: got %0d want 2", edge_count); end
        sync_in = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL qualify_return_low: got %b want 0", level_out); end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] exp16;
`ifdef EDGE_CNT_SAT_EN
        exp16 = 4'd15;
`else
        exp16 = 4'd0;
`endif
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_vec++; if (edge_count !== 4'd0) begin n_miss++; $display("FAIL clr_count: got %0d want 0", edge_count); end
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL clr_no_fsm_effect: got %b want 0", level_out); end
        for (int p = 1; p <= 16; p++) begin
            sync_in = 1'b1;
            for (int i = 0; i < 4; i++) step();
            sync_in = 1'b0;
            for (int i = 0; i < 4; i++) step();
            if (p == 15) begin
                n_vec++; if (edge_count !== 4'd15) begin n_miss++; $display("FAIL count_15: got %0d want 15", edge_count); end
            end
        end
        n_vec++; if (edge_count !== exp16) begin n_miss++; $display("FAIL count_16: got %0d want %0d", edge_count, exp16); end
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL wrap_level: got %b want 0", level_out); end
    endtask

    task automatic test_clr_priority();
        sync_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_vec++; if (rise_pulse !== 1'b1) begin n_miss++; $display("FAIL clr_prio_rise: got %b want 1", rise_pulse); end
        n_vec++; if (level_out !== 1'b1) begin n_miss++; $display("FAIL clr_prio_level: got %b want 1", level_out); end
        n_vec++; if (edge_count !== 4'd0) begin n_miss++; $display("FAIL clr_prio_count: got %0d want 0", edge_count); end
        sync_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL clr_prio_fall_level: got %b want 0", level_out); end
        n_vec++; if (fall_pulse !== 1'b1) begin n_miss++; $display("FAIL clr_prio_fall_pulse: got %b want 1", fall_pulse); end
    endtask

    task automatic test_reset_mid_check();
        sync_in = 1'b1;
        step();
        step();
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL midrst_level: got %b want 0", level_out); end
        n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL midrst_rise: got %b want 0", rise_pulse); end
        step();
        n_vec++; if (rise_pulse !== 1'b0) begin n_miss++; $display("FAIL midrst_held_rise: got %b want 0", rise_pulse); end
        n_vec++; if (edge_count !== 4'd0) begin n_miss++; $display("FAIL midrst_count: got %0d want 0", edge_count); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL midrst_restart_level[%0d]: got %b want 0", i, level_out); end
        end
        step();
        n_vec++; if (rise_pulse !== 1'b1) begin n_miss++; $display("FAIL midrst_restart_rise: got %b want 1", rise_pulse); end
        n_vec++; if (edge_count !== 4'd1) begin n_miss++; $display("FAIL midrst_restart_count: got %0d want 1", edge_count); end
        sync_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_vec++; if (level_out !== 1'b0) begin n_miss++; $display("FAIL midrst_return_low: got %b want 0", level_out); end
    endtask

    task automatic test_random();
        logic lvl;
        int   len;
        int   dut_pulses;
        int   mdl_pulses;
        lvl        = 1'b0;
        dut_pulses = 0;
        mdl_pulses = 0;
        for (int r = 0; r < 60; r++) begin
            lvl = ~lvl;
            len = int'($urandom_range(10, 1));
            for (int c = 0; c < len; c++) begin
                sync_in = lvl;
                step();
                dut_pulses += int'(rise_pulse) + int'(fall_pulse);
                mdl_pulses += int'(m_rise) + int'(m_fall);
                n_vec++; if (level_out !== m_level) begin n_miss++; $display("FAIL rand_level run %0d cyc %0d: got %b want %b", r, c, level_out, m_level); end
                n_vec++; if (rise_pulse !== m_rise) begin n_miss++; $display("FAIL rand_rise run %0d cyc %0d: got %b want %b", r, c, rise_pulse, m_rise); end
                n_vec++; if (fall_pulse !== m_fall) begin n_miss++; $display("FAIL rand_fall run %0d cyc %0d: got %b want %b", r, c, fall_pulse, m_fall); end
                n_vec++; if (edge_count !== m_cnt) begin n_miss++; $display("FAIL rand_count run %0d cyc %0d: got %0d want %0d", r, c, edge_count, m_cnt); end
                n_vec++; if ((rise_pulse & fall_pulse) !== 1'b0) begin n_miss++; $display("FAIL rand_exclusive run %0d cyc %0d: got rise=%b fall=%b want not both", r, c, rise_pulse, fall_pulse); end
            end
        end
        n_vec++; if (dut_pulses !== mdl_pulses) begin n_miss++; $display("FAIL rand_pulse_total: got %0d want %0d", dut_pulses, mdl_pulses); end
    endtask

    initial begin
        test_reset();
        test_fall();
        test_glitch();
        test_wrap();
        test_clr_priority();
        test_reset_mid_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
